// File: rtl/seven_segment_decoder_if.sv
// Bus bundle between a multiplexed 7-segment source and the sniffer/decoder.
// The slave modport is the decoder; the master modport is whatever drives the pins.
interface seven_segment_decoder_if;
    logic [6:0]  cat_in;
    logic [7:0]  an_in;
    logic        err_clr_in;
    logic [31:0] val_out;
    logic        frame_done_out;
    logic [7:0]  seen_out;
    logic        err_out;

    modport master (
        output cat_in, an_in, err_clr_in,
        input  val_out, frame_done_out, seen_out, err_out
    );

    modport slave (
        input  cat_in, an_in, err_clr_in,
        output val_out, frame_done_out, seen_out, err_out
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// Decodes sampled multiplexed cathode/anode buses back into a 32-bit hex value.
// Optional macro SEVSEG_DEC_LIVE_EN: each legal capture also writes val_out directly.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    seven_segment_decoder_if.slave bus
);

    localparam logic [15:0] STABLE_TGT = 16'(STABLE_CYCLES);

    logic [6:0]  cat_s1, cat_sync, cat_prev;
    logic [7:0]  an_s1, an_sync, an_prev;
    logic [15:0] stab_cnt;
    logic [31:0] shadow;
    logic [31:0] val_q;
    logic        done_q;
    logic [7:0]  seen_q;
    logic        err_q;

    logic        stable;
    logic        sample;
    logic [7:0]  an_act;
    logic        one_hot;
    logic        multi_hot;
    logic [2:0]  cap_idx;
    logic [4:0]  dec;
    logic        capture;
    logic        err_set;
    logic [7:0]  seen_base;

    // Returns {legal, nibble} for an active-high {g..a} pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    // The sample fires on the edge where the saturating counter arrives at the target.
    always_comb begin
        stable    = (cat_sync == cat_prev) && (an_sync == an_prev);
        sample    = stable && (stab_cnt == STABLE_TGT - 16'd1);
        an_act    = ~an_sync;
        one_hot   = (an_act != 8'h00) && ((an_act & (an_act - 8'd1)) == 8'h00);
        multi_hot = (an_act != 8'h00) && !one_hot;
        cap_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_act[k]) cap_idx = 3'(k);
        end
        dec       = decode(~cat_sync);
        capture   = sample && one_hot && dec[4];
        err_set   = sample && (multi_hot || (one_hot && !dec[4]));
        seen_base = (seen_q == 8'hFF) ? 8'h00 : seen_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cat_s1   <= '0;
            cat_sync <= '0;
            cat_prev <= '0;
            an_s1    <= '0;
            an_sync  <= '0;
            an_prev  <= '0;
            stab_cnt <= '0;
            shadow   <= '0;
            val_q    <= '0;
            done_q   <= 1'b0;
            seen_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            cat_s1   <= bus.cat_in;
            cat_sync <= cat_s1;
            an_s1    <= bus.an_in;
            an_sync  <= an_s1;
            cat_prev <= cat_sync;
            an_prev  <= an_sync;

            if (!stable) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STABLE_TGT) begin
                stab_cnt <= stab_cnt + 16'd1;
            end

            // Completion clears the mask first so a same-cycle capture starts the next frame.
            done_q <= (seen_q == 8'hFF);
            if (seen_q == 8'hFF) begin
                val_q <= shadow;
            end
            seen_q <= capture ? (seen_base | an_act) : seen_base;

            if (capture) begin
                shadow[4*cap_idx +: 4] <= dec[3:0];
`ifdef SEVSEG_DEC_LIVE_EN
                val_q[4*cap_idx +: 4]  <= dec[3:0];
`endif
            end

            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr_in) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.val_out        = val_q;
    assign bus.frame_done_out = done_q;
    assign bus.seen_out       = seen_q;
    assign bus.err_out        = err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder with a frame scoreboard.
module tb_seven_segment_decoder;

    localparam int S     = 4;
    localparam int DWELL = S + 6;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    seven_segment_decoder_if bus ();

    seven_segment_decoder #(.STABLE_CYCLES(S)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];
    logic prev_done = 1'b0;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tab[n];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic [7:0] an, input logic [6:0] pat, input int cycles);
        bus.an_in  = an;
        bus.cat_in = ~pat;
        repeat (cycles) @(negedge clk_in);
    endtask

    task automatic show_digit(input int d, input logic [3:0] n);
        apply_stimulus(~(8'd1 << d), seg(n), DWELL);
    endtask

    task automatic send_frame(input logic [31:0] v, input bit rev);
        exp_q.push_back(v);
        for (int k = 0; k < 8; k++) begin
            int d;
            d = rev ? 7 - k : k;
            show_digit(d, v[4*d +: 4]);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk_in);
        check_output("scoreboard_drain", exp_q.size(), 0);
        check_output("seen_after_frame", bus.seen_out, 8'h00);
    endtask

    // Scoreboard side: every completion pulse pops one expected frame.
    always @(negedge clk_in) begin
        if (bus.frame_done_out) begin
            check_output("done_single_cycle", prev_done, 1'b0);
            check_output("frame_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check_output("frame_value", bus.val_out, exp_q.pop_front());
        end
        prev_done = bus.frame_done_out;
    end

    initial begin
        bus.an_in      = 8'hFF;
        bus.cat_in     = 7'h7F;
        bus.err_clr_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_output("reset_val", bus.val_out, 32'h0);
        check_output("reset_seen", bus.seen_out, 8'h00);
        check_output("reset_err", bus.err_out, 1'b0);
        check_output("reset_done", bus.frame_done_out, 1'b0);
        rst_in = 1'b1;
        repeat (DWELL) @(negedge clk_in);

        $display("[TB] loopback DEADBEEF, reverse scan");
        send_frame(32'hDEADBEEF, 1'b1);
        wait_drain();
        check_output("loopback_err", bus.err_out, 1'b0);

        $display("[TB] digit 0 = 0, digits 1..7 = 8, with a recapture");
        exp_q.push_back(32'h88888880);
        show_digit(1, 4'h3);
        show_digit(0, 4'h0);
        for (int d = 1; d < 8; d++) apply_stimulus(~(8'd1 << d), 7'h7F, DWELL);
        wait_drain();

        $display("[TB] glitch filter on digit 3");
        for (int c = 0; c < S - 1; c++) apply_stimulus(8'hF7, (c % 2 == 0) ? 7'h5B : 7'h06, 1);
        apply_stimulus(8'hF7, 7'h06, DWELL);
        check_output("glitch_seen", bus.seen_out, 8'h08);
        exp_q.push_back(32'h76541210);
        show_digit(0, 4'h0);
        show_digit(1, 4'h1);
        show_digit(2, 4'h2);
        for (int d = 4; d < 8; d++) show_digit(d, 4'(d));
        wait_drain();

        $display("[TB] error cases");
        apply_stimulus(8'hFC, 7'h3F, DWELL);
        check_output("multi_anode_err", bus.err_out, 1'b1);
        check_output("multi_anode_seen", bus.seen_out, 8'h00);
        apply_stimulus(8'hFB, 7'h00, DWELL);
        check_output("illegal_err", bus.err_out, 1'b1);
        check_output("illegal_seen", bus.seen_out, 8'h00);
        bus.err_clr_in = 1'b1;
        @(negedge clk_in);
        bus.err_clr_in = 1'b0;
        check_output("err_clear", bus.err_out, 1'b0);

        $display("[TB] long blank interval");
        show_digit(5, 4'h3);
        check_output("pre_blank_seen", bus.seen_out, 8'h20);
        apply_stimulus(8'hFF, 7'h3F, 100);
        check_output("blank_seen", bus.seen_out, 8'h20);
        check_output("blank_err", bus.err_out, 1'b0);

        $display("[TB] reset mid-frame");
        for (int d = 0; d < 5; d++) show_digit(d, 4'h9);
        check_output("midframe_seen", bus.seen_out, 8'h3F);
        #2 rst_in = 1'b0;
        #1;
        check_output("async_reset_seen", bus.seen_out, 8'h00);
        check_output("async_reset_val", bus.val_out, 32'h0);
        check_output("async_reset_err", bus.err_out, 1'b0);
        @(negedge clk_in);
        bus.an_in  = 8'hFF;
        bus.cat_in = 7'h7F;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (DWELL) @(negedge clk_in);
        show_digit(0, 4'h8);
        check_output("post_reset_seen", bus.seen_out, 8'h01);
`ifdef SEVSEG_DEC_LIVE_EN
        check_output("live_val", bus.val_out, 32'h00000008);
`else
        check_output("held_val", bus.val_out, 32'h00000000);
`endif
        exp_q.push_back(32'h12345678);
        for (int d = 1; d < 8; d++) show_digit(d, 4'(8 - d));
        wait_drain();
        check_output("final_err", bus.err_out, 1'b0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the active-low cathode and anode buses and decodes each digit's segment pattern back to a hex nibble.
- Reassembles the 32-bit value and publishes it once all 8 digits have been captured.
- Used for loopback self-test of the display path and for sniffing external multiplexed displays.

Parameters:
STABLE_CYCLES, 16, consecutive synchronized cycles cat/an must hold unchanged before a digit is sampled (glitch/ghosting filter); legal range 1..65535.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
cat_in  input  7  cathodes, active-low; bit0=a … bit6=g
an_in  input  8  anodes, active-low; bit i selects digit i (val nibble [4i+3:4i])
val_out  output  32  last complete decoded frame
frame_done_out  output  1  one-cycle pulse when val_out is updated
seen_out  output  8  digits captured in the frame in progress
err_out  output  1  sticky error flag
err_clr_in  input  1  synchronous clear of err_out

Behaviour:
- Reset (rst_in low, async): val_out=0, frame_done_out=0, seen_out=0, err_out=0; shadow register, stability counter and sync flops cleared. Release is clean mid-frame; decoding restarts with an empty seen mask.
- Input sync: cat_in and an_in each pass through a 2-flop synchronizer. All decisions below use the synchronized values (cs, as).
- Stability counter (16 bits):
  - Resets to 0 on any cycle where {cs,as} differs from the previous cycle.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Sample event: fires on the single cycle the counter reaches STABLE_CYCLES. At most one sample per dwell. A held input never resamples.
- Decode, on the sample event:
  - Pattern p = ~cs. Legal map, p as {g..a} hex:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D
    - 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C
    - C=39, D=5E, E=79, F=71
  - If ~as has no bits set: blank interval, ignored, no error.
  - If ~as has two or more bits set: set err_out, no capture.
  - If ~as is one-hot with index i:
    - Legal p: shadow[4i+3:4i] = nibble, seen_out[i] = 1.
    - Illegal p: set err_out, seen_out unchanged.
- Frame completion:
  - On the cycle after seen_out becomes 8'hFF: val_out = shadow, frame_done_out = 1 for exactly one cycle, seen_out = 0.
  - Recapturing an already-seen digit overwrites its shadow nibble; this is not an error.
  - A sample that lands on the completion cycle is applied after the clear, so it counts as the first digit of the next frame.
- Latency, from a stable pin change to seen_out update: 2 + STABLE_CYCLES + 1 cycles. From the final digit to val_out update: +1 cycle.
- err_out:
  - Sticky.
  - Cleared when err_clr_in = 1 unless a new error occurs the same cycle; set wins.
- Scan direction and digit order are arbitrary; any permutation completes a frame.

Optional Feature:
SEVSEG_DEC_LIVE_EN
- Defined:
  - Each legal capture also writes its nibble directly into val_out on the same cycle as the shadow write.
  - frame_done_out still pulses on completion.
- Undefined: val_out changes only on frame completion; the shadow register is the only live copy.

Test Plan:
1. Loopback with the display driver: val=32'hDEADBEEF, COUNT_TO=3, STABLE_CYCLES=2.
   → frame_done_out pulses within 2 scan rotations, val_out=DEADBEEF, err_out=0.
2. Hold an_in=8'hFE (digit 0), cat_in=7'h40 (pattern 3F, digit "0"); then sweep digits 1..7 with pattern 0x7F.
   → val_out=88888880 after the 8th capture; frame_done_out high exactly 1 cycle.
3. Glitch: cat_in toggles for STABLE_CYCLES-1 cycles, then settles on pattern 06 at digit 3.
   → only one capture; seen_out=8'h08 and shadow nibble 3 = 1.
4. Errors:
   - an_in=8'hFC with a stable pattern → err_out=1, seen_out unchanged.
   - Then digit 2 with illegal pattern 0x00 → err_out stays 1, seen_out[2]=0.
   - Then err_clr_in pulse → err_out=0.
5. an_in=8'hFF, stable for 100 cycles → no capture, no error, seen_out unchanged.
6. Assert rst_in low mid-frame with seen_out=8'h3F → all outputs 0 immediately; after release, a full 8-digit scan of 12345678 → val_out=12345678.
   - Repeat with SEVSEG_DEC_LIVE_EN defined: val_out nibbles update per capture.
